mysystem_addr_sequencer: RTL
============================

# mysystem_addr_sequencer

Avalon-MM slave that autonomously steps an 8-bit note/sample address through a programmable range at a programmable rate, replacing per-note CPU writes to the address PIO. Sits on the Nios II data bus beside the PIO slaves; its `out_port` drives the same downstream note-ROM address lines. The Nios II configures range, tempo and mode, starts playback, and is interrupted at end of sequence.

## Interface
Parameters:
- `DIV_W`, 24: width of the tempo divider register.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `address` in 3: register word index.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe; write when `chipselect && ~write_n`.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read mux of `address`; unused bits 0.
- `out_port` out 8: current sequence address (register `cur`).
- `step` out 1: one-cycle pulse each time `cur` changes during playback.
- `irq` out 1: `done & irq_en`, registered.

## Operation
Register map (word index):
- 0 CTRL, R/W: bit0 `run`, bit1 `loop`, bit2 `irq_en`.
- 1 START, R/W [7:0].
- 2 END, R/W [7:0].
- 3 DIV, R/W [DIV_W-1:0]: cycles per step minus 1.
- 4 STATUS: read bit0 `busy` (state==PLAY), bit1 `done`; write 1 to bit1 clears `done`; other bits ignored.
- 5 CUR: read `cur`; write loads `cur` only when IDLE, ignored in PLAY.
- 6, 7: read 0, writes ignored.

Reset values: CTRL=0, START=0, END=0, DIV=0, `cur`=0, cnt=0, done=0, state=IDLE; so `out_port`=0, `step`=0, `irq`=0, `readdata` follows the address mux.

State machine:
- IDLE: CTRL write with bit0=1 -> `cur`<=START, cnt<=DIV, `step`<=1, state<=PLAY.
- PLAY, cnt!=0: cnt<=cnt-1.
- PLAY, cnt==0, `cur`!=END: `cur`<=`cur`+1 (mod 256), cnt<=DIV, `step`<=1.
- PLAY, cnt==0, `cur`==END, `loop`=1: `cur`<=START, cnt<=DIV, `step`<=1.
- PLAY, cnt==0, `cur`==END, `loop`=0: state<=IDLE, `run`<=0, `done`<=1; `cur` holds END; no `step`.
- PLAY, CTRL write with bit0=0: state<=IDLE immediately, `cur` holds, `done` unchanged.
- PLAY, CTRL write with bit0=1: restart (`cur`<=START, cnt<=DIV, `step`<=1).

Arithmetic/boundary rules:
- END<START is legal: `cur` wraps 255->0 and continues to END.
- START==END: one step per loop; non-loop finishes after DIV+1 cycles.
- START/END/DIV writes in PLAY: take effect at the next compare/reload, with no restart.
- `done` set and STATUS clear in the same cycle: set wins.
- `loop` cleared mid-PLAY: sequence ends at the next END match.

## Timing
- Write sampled at rising edge E; registers, state, `cur` and `step` update at E.
- `out_port` = START from E; the first advance occurs at E+(DIV+1) cycles. Step period is DIV+1 cycles.
- `step` is high for exactly the one cycle following each `cur` load.
- `done` is set at the edge where END expires; `irq` rises one cycle later and stays high until `done` is cleared or `irq_en`=0, then falls one cycle later.
- `readdata` is combinational, zero wait states; it reflects register state before the current edge.
- `reset_n` low at any time clears all state asynchronously, including mid-PLAY; `irq` and `step` drop immediately.

## Test plan
- Reset: hold `reset_n` low mid-PLAY -> `out_port`=0, `irq`=0, `step`=0, STATUS reads 0, CTRL reads 0.
- Basic run: START=3, END=6, DIV=4, CTRL=0x5 -> `out_port` 3,4,5,6 at 5-cycle spacing, 4 `step` pulses, `done`=1 five cycles after 6 is loaded, `irq`=1 the next cycle; write STATUS=2 -> `irq`=0.
- Loop and wrap: START=0xFE, END=0x01, DIV=0, CTRL=0x3 -> sequence FE,FF,00,01,FE,... one per cycle, never `done`; write CTRL=0 -> `cur` freezes, `busy`=0.
- Stop/CUR: in PLAY, CUR write of 0x40 is ignored; after stop, CUR write of 0x40 -> `out_port`=0x40, no `step`.
- Collision: at the cycle `done` sets, also write STATUS=2 -> `done` reads 1 afterward.
- Live retune: during PLAY with DIV=9, write DIV=1 -> the current interval completes at 10 cycles, subsequent intervals are 2 cycles.

Source files
------------

// File: rtl/mysystem_addr_sequencer.sv
// rtl/mysystem_addr_sequencer.sv - Avalon-MM address sequencer stepping cur through START..END
module mysystem_addr_sequencer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [7:0]       out_port,
  output logic             step,
  output logic             irq
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_START  = 3'd1;
  localparam logic [2:0] A_END    = 3'd2;
  localparam logic [2:0] A_DIV    = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_CUR    = 3'd5;

  logic [0:0]       state;
  logic             ctrl_run;
  logic             ctrl_loop;
  logic             ctrl_irq_en;
  logic [7:0]       start_r;
  logic [7:0]       end_r;
  logic [DIV_W-1:0] div_r;
  logic [7:0]       cur;
  logic [DIV_W-1:0] cnt;
  logic             done;

  logic wr_en;
  logic wr_ctrl;
  logic wr_status;
  logic wr_cur;
  logic done_set;
  logic done_clr;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en && (address == A_CTRL);
  assign wr_status = wr_en && (address == A_STATUS);
  assign wr_cur    = wr_en && (address == A_CUR);

  // A CTRL write in the same cycle pre-empts the end-of-sequence decision.
  assign done_set = (state == PLAY) && !wr_ctrl && (cnt == '0) &&
                    (cur == end_r) && !ctrl_loop;
  assign done_clr = wr_status && writedata[1];

  assign out_port = cur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ctrl_run    <= 1'b0;
      ctrl_loop   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      start_r     <= '0;
      end_r       <= '0;
      div_r       <= '0;
      cur         <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      step        <= 1'b0;
      irq         <= 1'b0;
    end else begin
      step <= 1'b0;
      irq  <= done & ctrl_irq_en;

      if (wr_en && address == A_START) start_r <= writedata[7:0];
      if (wr_en && address == A_END)   end_r   <= writedata[7:0];
      if (wr_en && address == A_DIV)   div_r   <= writedata[DIV_W-1:0];

      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;

      if (wr_ctrl) begin
        ctrl_run    <= writedata[0];
        ctrl_loop   <= writedata[1];
        ctrl_irq_en <= writedata[2];
        if (writedata[0]) begin
          cur   <= start_r;
          cnt   <= div_r;
          step  <= 1'b1;
          state <= PLAY;
        end else begin
          state <= IDLE;
        end
      end else if (state == PLAY) begin
        if (cnt != '0) begin
          cnt <= cnt - DIV_W'(1);
        end else if (cur != end_r) begin
          cur  <= cur + 8'd1;
          cnt  <= div_r;
          step <= 1'b1;
        end else if (ctrl_loop) begin
          cur  <= start_r;
          cnt  <= div_r;
          step <= 1'b1;
        end else begin
          state    <= IDLE;
          ctrl_run <= 1'b0;
        end
      end else if (wr_cur) begin
        cur <= writedata[7:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_CTRL:   readdata[2:0]       = {ctrl_irq_en, ctrl_loop, ctrl_run};
      A_START:  readdata[7:0]       = start_r;
      A_END:    readdata[7:0]       = end_r;
      A_DIV:    readdata[DIV_W-1:0] = div_r;
      A_STATUS: readdata[1:0]       = {done, state == PLAY};
      A_CUR:    readdata[7:0]       = cur;
      default:  readdata            = '0;
    endcase
  end

endmodule
